mem_wb_elastic_reg: RTL
=======================

# mem_wb_elastic_reg

Parametrised, elastic MEM→WB pipeline register for the pipelined core. It carries the same payload as the fixed MEM stage register: write-back enable, memory-read enable, ALU result, memory read data and destination register. It adds valid/ready handshaking, a one-entry skid buffer for full throughput under backpressure, a FREEZE input for memory stalls and a FLUSH input that inserts a bubble. It sits between the MEM stage and the WB stage and replaces the always-loading register once the memory path becomes multi-cycle.

## Interface
- DATA_W, 32, width of ALU result and memory data fields
- DEST_W, 4, width of destination register index
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- FREEZE  in  1  hold all state; no accept, no release
- FLUSH  in  1  synchronous: discard all held entries and the current input
- In_Valid  in  1  MEM stage presents an entry
- In_Ready  out  1  block can accept this cycle
- WB_EN_In, MEM_R_EN_In  in  1 each  control bits
- ALU_Res_In, Data_In  in  DATA_W each  payload
- Dest_In  in  DEST_W  destination index
- Out_Valid  out  1  entry presented to WB
- Out_Ready  in  1  WB consumes the entry this cycle
- WB_EN_Out, MEM_R_EN_Out  out  1 each  control bits, gated by Out_Valid
- ALU_Res_Out, Data_Out  out  DATA_W each  payload of the head entry
- Dest_Out  out  DEST_W  destination of the head entry
- Occupancy  out  2  number of held entries, 0 to 2

## Operation
- Storage: a main register (head, drives outputs) and a skid register, each holding the full payload plus a valid bit.
- States: EMPTY (0 entries), ONE (main only), TWO (main plus skid).
- accept = In_Valid & In_Ready.
- take = Out_Valid & Out_Ready & !FREEZE.
- In_Ready = !FREEZE & (state != TWO). It depends combinationally on FREEZE only.
- Out_Valid = (state != EMPTY). It is a pure register output.
- Transitions:
  - EMPTY: accept → ONE, main loads the input.
  - ONE, accept & take → ONE, main loads the input.
  - ONE, accept & !take → TWO, skid loads the input.
  - ONE, !accept & take → EMPTY.
  - ONE, neither → hold.
  - TWO: no accept is possible. take → ONE, main loads skid. Otherwise hold.
- FLUSH: next state EMPTY and both valid bits cleared. Any input offered that cycle is dropped. Payload registers may retain stale data.
- Priority: FLUSH > FREEZE > normal handshake. FLUSH is honoured while FREEZE is high.
- FREEZE with FLUSH low: state, payload and Occupancy are unchanged. In_Ready = 0. Out_Valid keeps its value; WB must not treat it as consumed.
- Bubble safety: WB_EN_Out and MEM_R_EN_Out are 0 whenever Out_Valid = 0. ALU_Res_Out, Data_Out and Dest_Out hold their last value.
- Ordering is strictly FIFO; entries are never reordered or duplicated.
- Occupancy = 0/1/2 for EMPTY/ONE/TWO.

## Timing
- Reset (asynchronous, RST high):
  - state EMPTY, all payload registers 0.
  - Out_Valid = 0, WB_EN_Out = 0, MEM_R_EN_Out = 0, ALU_Res_Out = 0, Data_Out = 0, Dest_Out = 0, Occupancy = 0.
  - In_Ready = 1 unless FREEZE is high.
- Reset released mid-transfer: all held entries are lost; the first accept after release goes to main.
- Latency: an entry accepted at edge N appears on the outputs after edge N, with Out_Valid = 1 in cycle N+1.
- Throughput: 1 entry per cycle when Out_Ready is held high, with no bubbles.
- Backpressure: In_Ready deasserts one cycle after the cycle in which Out_Ready dropped while an entry was accepted. The skid absorbs that entry, so no data is lost.
- Simultaneous accept and take in ONE: the new entry replaces the head at the same edge.

## Test plan
- Reset then stream: RST pulse; In_Valid = 1, Out_Ready = 1, ALU_Res_In = 1, 2, 3… → Out_Valid rises one cycle later; ALU_Res_Out = 1, 2, 3… on consecutive cycles; Occupancy = 1 throughout.
- Backpressure: stream 0xA, 0xB, 0xC with Out_Ready = 0 from the 0xA output cycle → Occupancy = 2, In_Ready = 0, 0xC held off. Raise Out_Ready → outputs 0xA, 0xB, 0xC in order, none lost.
- Flush: state TWO holding 0x11 and 0x22; FLUSH = 1 with In_Valid = 1 on 0x33 → next cycle Out_Valid = 0, WB_EN_Out = 0, Occupancy = 0, and 0x33 is never output.
- Freeze: state ONE holding Dest = 5; FREEZE = 1 for 3 cycles with Out_Ready = 1 and In_Valid = 1 → In_Ready = 0, outputs stable at Dest_Out = 5, Occupancy = 1. After release the entry is taken once.
- Flush during freeze, plus async reset: FREEZE = 1 and FLUSH = 1 → next cycle Occupancy = 0. Then load 2 entries and assert RST between clock edges → all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/mem_wb_elastic_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_elastic_reg
//
// Elastic MEM->WB pipeline register. It carries the write-back payload
// (write-back enable, memory-read enable, ALU result, memory read data,
// destination index) from the MEM stage to the WB stage under a valid/ready
// handshake. A one-entry skid register lets the block keep full throughput
// when WB applies backpressure: In_Ready is a function of the state and
// FREEZE only, so an entry that arrives in the same cycle as Out_Ready drops
// is parked in the skid register instead of being lost.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   FREEZE            hold all state: nothing accepted, nothing released
//   FLUSH             synchronous bubble insert: drop held entries and input
//   In_Valid/In_Ready upstream handshake
//   *_In              incoming payload
//   Out_Valid/Out_Ready downstream handshake
//   *_Out             head-entry payload (control bits gated by Out_Valid)
//   Occupancy         number of held entries, 0..2
// ---------------------------------------------------------------------------
module mem_wb_elastic_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FREEZE,
  input  logic              FLUSH,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              WB_EN_In,
  input  logic              MEM_R_EN_In,
  input  logic [DATA_W-1:0] ALU_Res_In,
  input  logic [DATA_W-1:0] Data_In,
  input  logic [DEST_W-1:0] Dest_In,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              WB_EN_Out,
  output logic              MEM_R_EN_Out,
  output logic [DATA_W-1:0] ALU_Res_Out,
  output logic [DATA_W-1:0] Data_Out,
  output logic [DEST_W-1:0] Dest_Out,
  output logic [1:0]        Occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic main_valid;
  logic skid_valid;

  logic              main_wb_en;
  logic              main_mem_r_en;
  logic [DATA_W-1:0] main_alu_res;
  logic [DATA_W-1:0] main_data;
  logic [DEST_W-1:0] main_dest;

  logic              skid_wb_en;
  logic              skid_mem_r_en;
  logic [DATA_W-1:0] skid_alu_res;
  logic [DATA_W-1:0] skid_data;
  logic [DEST_W-1:0] skid_dest;

  logic accept;
  logic take;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;

  // In_Ready never looks at Out_Ready, which breaks the combinational
  // ready path between WB and MEM; the skid entry covers the one-cycle lag.
  assign In_Ready = !FREEZE && (state != TWO);
  assign accept   = In_Valid && In_Ready;
  assign take     = main_valid && Out_Ready && !FREEZE;

  // Next-state and load selection. FLUSH wins over everything, including
  // FREEZE, and suppresses every load so the offered input is dropped.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (FLUSH) begin
      next_state = EMPTY;
    end else if (!FREEZE) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            next_state   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && take) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            next_state   = TWO;
            load_skid_in = 1'b1;
          end else if (take) begin
            next_state = EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            next_state     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          next_state = EMPTY;
        end
      endcase
    end
  end

  // State register; the valid bits are registered alongside so Out_Valid is
  // a direct flop output with no decode in front of the WB stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      state      <= next_state;
      main_valid <= (next_state != EMPTY);
      skid_valid <= (next_state == TWO);
    end
  end

  // Head payload: refilled either from the input (pass-through or
  // replace-on-take) or from the skid when the older entry drains.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_wb_en    <= 1'b0;
      main_mem_r_en <= 1'b0;
      main_alu_res  <= '0;
      main_data     <= '0;
      main_dest     <= '0;
    end else if (load_main_in) begin
      main_wb_en    <= WB_EN_In;
      main_mem_r_en <= MEM_R_EN_In;
      main_alu_res  <= ALU_Res_In;
      main_data     <= Data_In;
      main_dest     <= Dest_In;
    end else if (load_main_skid) begin
      main_wb_en    <= skid_wb_en;
      main_mem_r_en <= skid_mem_r_en;
      main_alu_res  <= skid_alu_res;
      main_data     <= skid_data;
      main_dest     <= skid_dest;
    end
  end

  // Skid payload: only written when an entry arrives while the head is
  // still waiting for WB.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      skid_wb_en    <= 1'b0;
      skid_mem_r_en <= 1'b0;
      skid_alu_res  <= '0;
      skid_data     <= '0;
      skid_dest     <= '0;
    end else if (load_skid_in) begin
      skid_wb_en    <= WB_EN_In;
      skid_mem_r_en <= MEM_R_EN_In;
      skid_alu_res  <= ALU_Res_In;
      skid_data     <= Data_In;
      skid_dest     <= Dest_In;
    end
  end

  // Control bits are masked when no entry is presented so a bubble can
  // never trigger a register-file write; the data fields just hold.
  assign Out_Valid    = main_valid;
  assign WB_EN_Out    = main_wb_en && main_valid;
  assign MEM_R_EN_Out = main_mem_r_en && main_valid;
  assign ALU_Res_Out  = main_alu_res;
  assign Data_Out     = main_data;
  assign Dest_Out     = main_dest;
  assign Occupancy    = {skid_valid, main_valid && !skid_valid};

endmodule
